// File: rtl/coin_payout_sequencer.sv
// Coin payout sequencer: arbitrates change and coin-return requests and pays each out
// greedily from the 5/2/1 hoppers, one coin at a time, with inventory tracking and timeout fault.
module coin_payout_sequencer #(
   parameter int INV_W    = 4,
   parameter int INV_INIT = 8,
   parameter int TIMEOUT  = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             chg_req,
   input  logic [3:0]       chg_amt,
   input  logic             cr_req,
   input  logic [3:0]       cr_amt,
   output logic             chg_ack,
   output logic             cr_ack,
   output logic [2:0]       hop_fire,
   input  logic             hop_done,
   input  logic             refill,
   output logic [INV_W-1:0] inv5,
   output logic [INV_W-1:0] inv2,
   output logic [INV_W-1:0] inv1,
   output logic             busy,
   output logic             done,
   output logic             done_src,
   output logic [3:0]       shortfall,
   output logic             fault,
   output logic [2:0]       fsm_state
);

   // Handshakes: req is a level held until its one-cycle ack; hop_fire is a one-cycle
   // pulse per coin and hop_done is only honoured while waiting for that coin.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_FIRE   = 3'd2,
      S_WAIT   = 3'd3,
      S_FINISH = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   localparam logic [INV_W-1:0] INV_FULL  = INV_W'(INV_INIT);
   localparam logic [7:0]       TIMER_MAX = 8'(TIMEOUT);

   state_t     state, state_next;
   logic [3:0] rem;
   logic       src;
   logic       last_grant;
   logic [2:0] sel;
   logic [7:0] timer;

   logic       grant_chg, grant_cr;
   logic [2:0] pick;
   logic [3:0] coin_val;
   logic [7:0] timer_inc;

   logic       chg_ack_d, cr_ack_d, done_d, done_src_d, busy_d, fault_d;
   logic [2:0] fire_d;
   logic [3:0] shortfall_d;

   assign fsm_state = state;
   assign timer_inc = timer + 8'd1;

   // On a tie, grant whichever requester did not win last time.
   assign grant_chg = chg_req && (!cr_req || last_grant);
   assign grant_cr  = cr_req && (!chg_req || !last_grant);

   always_comb begin
      pick = 3'b000;
      if (rem >= 4'd5 && inv5 != '0)
         pick = 3'b100;
      else if (rem >= 4'd2 && inv2 != '0)
         pick = 3'b010;
      else if (rem != 4'd0 && inv1 != '0)
         pick = 3'b001;
   end

   always_comb begin
      coin_val = 4'd0;
      if (sel[2])
         coin_val = 4'd5;
      else if (sel[1])
         coin_val = 4'd2;
      else if (sel[0])
         coin_val = 4'd1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (grant_chg || grant_cr) state_next = S_SELECT;
         S_SELECT: state_next = (pick != 3'b000) ? S_FIRE : S_FINISH;
         S_FIRE:   state_next = S_WAIT;
         S_WAIT: begin
            if (hop_done)
               state_next = S_SELECT;
            else if (timer_inc == TIMER_MAX)
               state_next = S_FAULT;
         end
         S_FINISH: state_next = S_IDLE;
         S_FAULT:  state_next = S_FAULT;
         default:  state_next = S_IDLE;
      endcase
   end

   // Next values for the registered outputs, so each pulse lines up with the state it belongs to.
   always_comb begin
      chg_ack_d   = (state == S_IDLE) && grant_chg;
      cr_ack_d    = (state == S_IDLE) && grant_cr;
      fire_d      = (state == S_SELECT) ? pick : 3'b000;
      done_d      = (state == S_SELECT) && (pick == 3'b000);
      done_src_d  = done_d ? src : 1'b0;
      shortfall_d = done_d ? rem : 4'd0;
      busy_d      = (state_next != S_IDLE);
      fault_d     = (state_next == S_FAULT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         chg_ack    <= 1'b0;
         cr_ack     <= 1'b0;
         hop_fire   <= 3'b000;
         done       <= 1'b0;
         done_src   <= 1'b0;
         shortfall  <= 4'd0;
         busy       <= 1'b0;
         fault      <= 1'b0;
         inv5       <= INV_FULL;
         inv2       <= INV_FULL;
         inv1       <= INV_FULL;
         rem        <= 4'd0;
         src        <= 1'b0;
         last_grant <= 1'b1;
         sel        <= 3'b000;
         timer      <= 8'd0;
      end else begin
         chg_ack   <= chg_ack_d;
         cr_ack    <= cr_ack_d;
         hop_fire  <= fire_d;
         done      <= done_d;
         done_src  <= done_src_d;
         shortfall <= shortfall_d;
         busy      <= busy_d;
         fault     <= fault_d;
         case (state)
            S_IDLE: begin
               if (grant_chg || grant_cr) begin
                  rem        <= grant_cr ? cr_amt : chg_amt;
                  src        <= grant_cr;
                  last_grant <= grant_cr;
               end else if (refill) begin
                  inv5 <= INV_FULL;
                  inv2 <= INV_FULL;
                  inv1 <= INV_FULL;
               end
            end
            S_SELECT: if (pick != 3'b000) sel <= pick;
            S_FIRE:   timer <= 8'd0;
            S_WAIT: begin
               if (hop_done) begin
                  rem <= rem - coin_val;
                  if (sel[2]) inv5 <= inv5 - INV_W'(1);
                  if (sel[1]) inv2 <= inv2 - INV_W'(1);
                  if (sel[0]) inv1 <= inv1 - INV_W'(1);
               end else begin
                  timer <= timer_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
